// File: rtl/fp32_bn_pkg.sv
// fp32_bn_pkg: shared encodings and types for the batch-norm scheduler
package fp32_bn_pkg;
  typedef enum logic [2:0] {
    CFG_MU    = 3'd0,
    CFG_VAR   = 3'd1,
    CFG_GAMMA = 3'd2,
    CFG_BETA  = 3'd3,
    CFG_EPS   = 3'd4,
    CFG_RM    = 3'd5
  } cfg_sel_e;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;
  localparam int TAG_CH_W = 4;
  typedef struct packed {
    logic [TAG_CH_W-1:0] ch;
    logic                last;
  } tag_t;
  typedef struct packed {
    logic [31:0] y;
    tag_t        tag;
  } res_t;
endpackage

// File: rtl/fp32_bn_fifo.sv
// fp32_bn_fifo: synchronous FIFO with occupancy count and no write-to-read bypass
module fp32_bn_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  // flags, head word and next pointers; a push into a full FIFO or pop from an empty one is ignored
  always_comb begin
    full_o  = cnt_q == CW'(DEPTH);
    empty_o = cnt_q == '0;
    count_o = cnt_q;
    dout_o  = mem_q[rd_q];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wr_d    = do_push ? (wr_q == AW'(DEPTH - 1) ? '0 : wr_q + AW'(1)) : wr_q;
    rd_d    = do_pop ? (rd_q == AW'(DEPTH - 1) ? '0 : rd_q + AW'(1)) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset; the occupancy count marks what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/fp32_bn_scheduler.sv
// fp32_bn_scheduler: credit-based issue and in-order result buffering for fp32_batchnorm
module fp32_bn_scheduler
  import fp32_bn_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int BN_LATENCY = 24,
  parameter int OUT_DEPTH = 32,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [2:0]      cfg_sel,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [31:0]     cfg_data,
  output logic            cfg_ready,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [CH_W-1:0] in_ch,
  input  logic            in_last,
  output logic            bn_ena,
  output logic [31:0]     bn_x,
  output logic [31:0]     bn_mu,
  output logic [31:0]     bn_var,
  output logic [31:0]     bn_gamma,
  output logic [31:0]     bn_beta,
  output logic [31:0]     bn_eps,
  output logic [1:0]      bn_rm,
  input  logic [31:0]     bn_y,
  input  logic            bn_y_valid,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic [CH_W-1:0] out_ch,
  output logic            out_last,
  output logic            frame_done,
  output logic            err
);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  if (OUT_DEPTH < BN_LATENCY + 2 || CH_W != TAG_CH_W) begin : g_bad_cfg
    $error("fp32_bn_scheduler: OUT_DEPTH must be >= BN_LATENCY+2 and CH_W must equal TAG_CH_W");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [31:0]     par_q [4][NUM_CH];
  logic [31:0]     eps_q;
  logic [1:0]      rm_q;
  logic            err_q, err_d;
  logic            bn_ena_q;
  logic [31:0]     bn_x_q, bn_mu_q, bn_var_q, bn_gamma_q, bn_beta_q, bn_eps_q;
  logic [1:0]      bn_rm_q;
  logic            accept, pop, ret, bad_ch, cfg_ok, cfg_ch_ok;
  logic [CH_W-1:0] ch_eff;
  tag_t            tag_in, tag_out;
  res_t            res_in, res_out;
  logic            tag_full, tag_empty, out_full, out_empty;
  logic [CW-1:0]   tag_cnt, out_cnt;

  // handshake readiness and output presentation; data reads as zero while the buffer is empty
  always_comb begin
    cfg_ready  = state_q == IDLE;
    in_ready   = state_q != DRAIN && credits_q < CW'(OUT_DEPTH);
    out_valid  = !out_empty;
    out_y      = out_valid ? res_out.y : '0;
    out_ch     = out_valid ? res_out.tag.ch : '0;
    out_last   = out_valid && res_out.tag.last;
    bn_ena     = bn_ena_q;
    bn_x       = bn_x_q;
    bn_mu      = bn_mu_q;
    bn_var     = bn_var_q;
    bn_gamma   = bn_gamma_q;
    bn_beta    = bn_beta_q;
    bn_eps     = bn_eps_q;
    bn_rm      = bn_rm_q;
    err        = err_q;
  end

  // transfer strobes, channel sanitising, credit update and error collection
  always_comb begin
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
    ret       = bn_y_valid && !tag_empty;
    bad_ch    = {1'b0, in_ch} >= (CH_W + 1)'(NUM_CH);
    ch_eff    = bad_ch ? '0 : in_ch;
    cfg_ok    = cfg_we && cfg_ready;
    cfg_ch_ok = {1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH);
    tag_in    = '{ch: ch_eff, last: in_last};
    res_in    = '{y: bn_y, tag: tag_out};
    credits_d = credits_q + CW'(accept) - CW'(pop);
    err_d     = err_q || (cfg_we && !cfg_ready) || (accept && bad_ch) || (bn_y_valid && tag_empty);
  end

  // frame sequencing; IDLE is re-entered only once every issued result has been popped
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    if (state_q != DRAIN && accept) state_d = in_last ? DRAIN : RUN;
    if (state_q == DRAIN && credits_d == '0) begin
      state_d    = IDLE;
      frame_done = 1'b1;
    end
  end

  // state, credits and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  // per-channel parameter table plus global eps and rounding mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < NUM_CH; c++)
          par_q[s][c] <= '0;
      eps_q <= '0;
      rm_q  <= '0;
    end else if (cfg_ok) begin
      if (!cfg_sel[2] && cfg_ch_ok) par_q[cfg_sel[1:0]][cfg_ch] <= cfg_data;
      if (cfg_sel == CFG_EPS) eps_q <= cfg_data;
      if (cfg_sel == CFG_RM) rm_q <= cfg_data[1:0];
    end
  end

  // operand registers loaded on accept; the strobe lasts exactly one cycle per element
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bn_ena_q   <= 1'b0;
      bn_x_q     <= '0;
      bn_mu_q    <= '0;
      bn_var_q   <= '0;
      bn_gamma_q <= '0;
      bn_beta_q  <= '0;
      bn_eps_q   <= '0;
      bn_rm_q    <= '0;
    end else begin
      bn_ena_q <= accept;
      if (accept) begin
        bn_x_q     <= in_x;
        bn_mu_q    <= par_q[0][ch_eff];
        bn_var_q   <= par_q[1][ch_eff];
        bn_gamma_q <= par_q[2][ch_eff];
        bn_beta_q  <= par_q[3][ch_eff];
        bn_eps_q   <= eps_q;
        bn_rm_q    <= rm_q;
      end
    end
  end

  // every credit is held either by a tag awaiting its result or by a buffered result
  always_ff @(posedge clk) begin
    if (!rst)
      assert (int'(credits_q) == int'(tag_cnt) + int'(out_cnt) && !(accept && tag_full) && !(ret && out_full))
        else $error("fp32_bn_scheduler: credit and buffer occupancy disagree");
  end

  fp32_bn_fifo #(.W($bits(tag_t)), .DEPTH(OUT_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (ret),
    .din_i   (tag_in),
    .dout_o  (tag_out),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .count_o (tag_cnt)
  );

  fp32_bn_fifo #(.W($bits(res_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ret),
    .pop_i   (pop),
    .din_i   (res_in),
    .dout_o  (res_out),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_cnt)
  );
endmodule

// File: tb/tb_fp32_bn_scheduler.sv
// tb_fp32_bn_scheduler: directed checks of issue, ordering, credits, config gating and reset
module tb_fp32_bn_scheduler;
  import fp32_bn_pkg::*;
  localparam int NUM_CH = 16;
  localparam int L = 24;
  localparam int DEPTH = 32;

  typedef struct {
    logic [31:0] x;
    logic [3:0]  ch;
    logic        last;
    logic [31:0] y;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_we = 1'b0, cfg_ready;
  logic [2:0]  cfg_sel = '0;
  logic [3:0]  cfg_ch = '0;
  logic [31:0] cfg_data = '0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [31:0] in_x = '0;
  logic [3:0]  in_ch = '0;
  logic        bn_ena;
  logic [31:0] bn_x, bn_mu, bn_var, bn_gamma, bn_beta, bn_eps, bn_y;
  logic [1:0]  bn_rm;
  logic        bn_y_valid, out_valid, out_ready = 1'b1, out_last, frame_done, err;
  logic [31:0] out_y;
  logic [3:0]  out_ch;

  int n_tests = 0, n_fail = 0, pop_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  vec_t exp_q[$];
  logic [31:0] sh [4][NUM_CH];
  logic [31:0] sh_eps;
  logic [1:0]  sh_rm;

  always #5 clk = ~clk;

  fp32_bn_scheduler #(.NUM_CH(NUM_CH), .BN_LATENCY(L), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_ch(in_ch),
    .in_last(in_last), .bn_ena(bn_ena), .bn_x(bn_x), .bn_mu(bn_mu), .bn_var(bn_var),
    .bn_gamma(bn_gamma), .bn_beta(bn_beta), .bn_eps(bn_eps), .bn_rm(bn_rm), .bn_y(bn_y),
    .bn_y_valid(bn_y_valid), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_ch(out_ch), .out_last(out_last), .frame_done(frame_done), .err(err)
  );

  // stand-in for the batch-norm pipeline: fixed latency, result is a checksum of every operand
  function automatic logic [31:0] bnf(input logic [31:0] x, mu, v, g, b, e, input logic [1:0] rm);
    return x + 32'd3 * mu + 32'd5 * v + 32'd7 * g + 32'd11 * b + 32'd13 * e + {30'd0, rm};
  endfunction

  logic [L-1:0] pv = '0;
  logic [31:0]  pd [L];
  logic         spur = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], bn_ena};
    pd[0] <= bnf(bn_x, bn_mu, bn_var, bn_gamma, bn_beta, bn_eps, bn_rm);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end
  assign bn_y_valid = pv[L-1] | spur;
  assign bn_y = pd[L-1];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] x, input logic [3:0] ch, input logic last);
    vec_t v;
    v.x = x; v.ch = ch; v.last = last;
    v.y = bnf(x, sh[0][ch], sh[1][ch], sh[2][ch], sh[3][ch], sh_eps, sh_rm);
    return v;
  endfunction

  task automatic clr_shadow();
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < NUM_CH; c++)
        sh[s][c] = '0;
    sh_eps = '0;
    sh_rm = '0;
  endtask

  // scoreboard: every output pop must match the oldest accepted element
  always @(negedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL out_unexpected: got y=%h ch=%0d with nothing pending, expected no output", out_y, out_ch);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("out_y", out_y, e.y);
        chk("out_ch", 32'(out_ch), 32'(e.ch));
        chk("out_last", 32'(out_last), 32'(e.last));
        if (pop_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        pop_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [3:0] ch, input logic [31:0] d, input bit upd);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (upd) begin
      if (sel < 3'd4) sh[sel[1:0]][ch] = d;
      else if (sel == 3'd4) sh_eps = d;
      else if (sel == 3'd5) sh_rm = d[1:0];
    end
  endtask

  task automatic send(input vec_t v, output int waited);
    waited = 0;
    in_valid = 1'b1; in_x = v.x; in_ch = v.ch; in_last = v.last;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) exp_q.push_back(v);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    int n = 0;
    bit seen = 0;
    while (n < 400 && !seen) begin
      @(negedge clk);
      seen = frame_done;
      n++;
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
    chk("cfg_ready_at_done", 32'(cfg_ready), 32'd0);
    if (poke) begin
      cfg_we = 1'b1; cfg_sel = CFG_MU; cfg_ch = 4'd5; cfg_data = 32'h0000_1234;
    end
    tick();
    cfg_we = 1'b0;
    chk("cfg_ready_after_done", 32'(cfg_ready), 32'd1);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_bn_ena"}, 32'(bn_ena), 32'd0);
    chk({tag, "_bn_x"}, bn_x, 32'd0);
    chk({tag, "_bn_mu"}, bn_mu, 32'd0);
    chk({tag, "_bn_eps"}, bn_eps, 32'd0);
    chk({tag, "_bn_rm"}, 32'(bn_rm), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_y"}, out_y, 32'd0);
    chk({tag, "_out_ch"}, 32'(out_ch), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[64];
    vec_t v;
    int w, wsum;
    clr_shadow();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("rst");

    // single element, exact latency and frame_done timing
    cfg_write(CFG_MU, 4'd3, 32'h4000_0000, 1);
    cfg_write(CFG_VAR, 4'd3, 32'h4080_0000, 1);
    cfg_write(CFG_GAMMA, 4'd3, 32'h3F80_0000, 1);
    cfg_write(CFG_BETA, 4'd3, 32'h0000_0000, 1);
    cfg_write(CFG_EPS, 4'd0, 32'h322B_CC77, 1);
    cfg_write(CFG_RM, 4'd0, 32'd1, 1);
    v = mk(32'h40A0_0000, 4'd3, 1'b1);
    in_valid = 1'b1; in_x = v.x; in_ch = v.ch; in_last = 1'b1;
    @(negedge clk);
    chk("single_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(v);
    tick();
    in_valid = 1'b0;
    chk("single_bn_ena", 32'(bn_ena), 32'd1);
    chk("single_bn_x", bn_x, 32'h40A0_0000);
    chk("single_bn_mu", bn_mu, 32'h4000_0000);
    chk("single_bn_var", bn_var, 32'h4080_0000);
    chk("single_bn_gamma", bn_gamma, 32'h3F80_0000);
    chk("single_bn_eps", bn_eps, 32'h322B_CC77);
    chk("single_bn_rm", 32'(bn_rm), 32'd1);
    chk("single_in_ready_drain", 32'(in_ready), 32'd0);
    for (int k = 1; k <= L + 1; k++) begin
      tick();
      if (k == 1) chk("single_bn_ena_pulse", 32'(bn_ena), 32'd0);
      if (k == L) chk("single_out_valid_early", 32'(out_valid), 32'd0);
    end
    chk("single_out_valid_on_time", 32'(out_valid), 32'd1);
    chk("single_frame_done", 32'(frame_done), 32'd1);
    chk("single_cfg_ready_low", 32'(cfg_ready), 32'd0);
    tick();
    chk("single_cfg_ready_back", 32'(cfg_ready), 32'd1);
    chk("single_out_valid_gone", 32'(out_valid), 32'd0);

    // 64 back-to-back elements over all channels
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_write(CFG_MU, 4'(c), 32'h0000_0100 + 32'(c), 1);
      cfg_write(CFG_VAR, 4'(c), 32'h0001_0000 * 32'(c + 1), 1);
      cfg_write(CFG_GAMMA, 4'(c), 32'h3F00_0000 ^ 32'(c), 1);
      cfg_write(CFG_BETA, 4'(c), 32'hA5A5_0000 | 32'(c * 7), 1);
    end
    for (int i = 0; i < 64; i++) tv[i] = mk(32'h0000_1000 + 32'(i * 3), 4'(i % NUM_CH), i == 63);
    pop_cnt = 0;
    for (int i = 0; i < 64; i++) send(tv[i], w);
    wait_done(0);
    chk("b2b_pop_count", 32'(pop_cnt), 32'd64);
    chk("b2b_one_per_cycle", 32'(last_cyc - first_cyc), 32'd63);

    // output stalled: exactly DEPTH accepts, then release and drain in order
    out_ready = 1'b0;
    pop_cnt = 0;
    wsum = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send(mk(32'h0000_2000 + 32'(i), 4'((i * 5) % NUM_CH), 1'b0), w);
      wsum += w;
    end
    chk("stall_no_early_backpressure", 32'(wsum), 32'd0);
    in_valid = 1'b1; in_x = 32'hFFFF_0000; in_ch = 4'd1; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_in_ready_low", 32'(in_ready), 32'd0);
    end
    chk("stall_no_output_pop", 32'(pop_cnt), 32'd0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(mk(32'h0000_3000, 4'd7, 1'b1), w);
    wait_done(0);
    chk("stall_pop_count", 32'(pop_cnt), 32'd33);
    chk("err_clean_so_far", 32'(err), 32'd0);

    // config writes outside IDLE are dropped, including the one landing with the final pop
    send(mk(32'h0000_4000, 4'd5, 1'b0), w);
    cfg_write(CFG_MU, 4'd5, 32'hDEAD_BEEF, 0);
    chk("run_cfg_err", 32'(err), 32'd1);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    send(mk(32'h0000_4001, 4'd5, 1'b1), w);
    wait_done(1);
    send(mk(32'h0000_4002, 4'd5, 1'b1), w);
    wait_done(0);
    cfg_write(CFG_MU, 4'd5, 32'h0000_0077, 1);
    send(mk(32'h0000_4003, 4'd5, 1'b1), w);
    wait_done(0);

    // reset with ten elements in flight, then late pipeline results and a clean frame
    for (int i = 0; i < 10; i++) send(mk(32'h0000_5000 + 32'(i), 4'(i), 1'b0), w);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    exp_q.delete();
    clr_shadow();
    tick();
    rst = 1'b0;
    repeat (L + 5) tick();
    chk("late_result_err", 32'(err), 32'd1);
    chk("late_result_no_out", 32'(out_valid), 32'd0);
    cfg_write(CFG_MU, 4'd2, 32'h0000_0011, 1);
    cfg_write(CFG_GAMMA, 4'd2, 32'h0000_0022, 1);
    cfg_write(CFG_EPS, 4'd0, 32'h0000_0033, 1);
    pop_cnt = 0;
    for (int i = 0; i < 3; i++) send(mk(32'h0000_6000 + 32'(i), 4'd2, i == 2), w);
    wait_done(0);
    chk("post_rst_pop_count", 32'(pop_cnt), 32'd3);

    // spurious pipeline result while idle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("spur_err_before", 32'(err), 32'd0);
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_err", 32'(err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("spur_no_out", 32'(out_valid), 32'd0);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
